// File: rtl/ntt_pkg.sv
// Shared constants for the NTT arithmetic blocks (adder, subtractor, multiplier):
// residue width, default modulus and the list of supported moduli.
package ntt_pkg;

    localparam int W = 30;

    // 2^30 - 2^18 + 1
    localparam logic [W-1:0] Q_DEFAULT = 30'd1073479681;

    // NTT-friendly primes below 2^30 that the arithmetic blocks may be built for.
    localparam int NUM_MODULI = 3;
    localparam logic [W-1:0] MODULI [NUM_MODULI] = '{
        30'd1073479681,
        30'd998244353,
        30'd469762049
    };

    function automatic logic in_range(input logic [W-1:0] x, input logic [W-1:0] q);
        return x < q;
    endfunction

endpackage

// File: rtl/mod_sub_core.sv
// Combinational correction for a modular difference: a borrow out of the raw
// subtraction means the value wrapped negative, so add the modulus back once.
module mod_sub_core
    import ntt_pkg::*;
#(
    parameter int CW = W
) (
    input  logic [CW:0]   diff,
    input  logic [CW-1:0] q,
    output logic [CW-1:0] c
);

    // The add wraps at 2^CW, which is exactly the correction for a negative difference.
    assign c = diff[CW-1:0] + (diff[CW] ? q : '0);

endmodule

// File: rtl/modular_subtractor_stream.sv
// Two-stage streaming (a - b) mod Q with valid/ready on both sides, a single
// global stall enable and a sticky flag for operands outside [0, Q).
module modular_subtractor_stream
    import ntt_pkg::*;
#(
    parameter logic [W-1:0] Q = Q_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_c,
    output logic         range_err
);

    logic         en;
    logic         v1_reg;
    logic         v2_reg;
    logic         rerr1_reg;
    logic [W:0]   d1_reg;
    logic [W-1:0] c_next;

    // Whole pipeline moves together; a full output that is not taken freezes everything.
    assign en        = ~v2_reg | out_ready;
    assign in_ready  = en;
    assign out_valid = v2_reg;

    mod_sub_core #(
        .CW(W)
    ) u_core (
        .diff (d1_reg),
        .q    (Q),
        .c    (c_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            rerr1_reg <= 1'b0;
            d1_reg    <= '0;
            out_c     <= '0;
            range_err <= 1'b0;
        end else if (en) begin
            v1_reg    <= in_valid;
            d1_reg    <= {1'b0, in_a} - {1'b0, in_b};
            rerr1_reg <= ~in_range(in_a, Q) | ~in_range(in_b, Q);
            v2_reg    <= v1_reg;
            out_c     <= c_next;
            // Only a real operand pair moving into stage 2 may raise the flag.
            if (v1_reg) begin
                range_err <= range_err | rerr1_reg;
            end
        end
    end

endmodule
